// File: rtl/l2_banked_sram.sv
// L2 SRAM wrapper: DATA_WIDTH x 2^ADDR_WIDTH built from 32-bit cuts, with req/gnt/rvalid
// handshake, optional output register and a post-reset zero-fill sequencer.

module generic_memory #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  i_clk,
  input  logic                  i_initn,
  input  logic                  i_cen,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic [31:0]           i_d,
  input  logic [3:0]            i_ben,
  output logic [31:0]           o_q
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  // Synchronous single-port cut; active-low enables, Q updates only on reads.
  always_ff @(posedge i_clk) begin
    if (!i_cen && i_initn) begin
      if (!i_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (!i_ben[b]) r_mem[i_a][8*b +: 8] <= i_d[8*b +: 8];
        end
      end else begin
        r_q <= r_mem[i_a];
      end
    end
  end

  assign o_q = r_q;

endmodule

module l2_banked_sram #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CUT_ADDR_WIDTH = 13,
  parameter int unsigned NB_ROWS        = 2,
  parameter bit          OUT_REG        = 1'b0,
  parameter bit          INIT_ZERO      = 1'b1,
  localparam int unsigned ADDR_WIDTH    = CUT_ADDR_WIDTH + $clog2(NB_ROWS),
  localparam int unsigned NB_BE         = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  output logic                  o_gnt,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_d,
  input  logic [NB_BE-1:0]      i_be,
  output logic [DATA_WIDTH-1:0] o_q,
  output logic                  o_rvalid,
  output logic                  o_init_done
);

  localparam int unsigned NB_CUTS   = DATA_WIDTH / 32;
  localparam int unsigned ROW_W     = (NB_ROWS > 1) ? $clog2(NB_ROWS) : 1;
  localparam int unsigned ROW_SLOTS = 1 << ROW_W;
  localparam logic [CUT_ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CUT_ADDR_WIDTH-1:0] r_init_cnt, w_cnt_nxt;
  logic                      r_init_done;
  logic                      r_rd_vld;
  logic [ROW_W-1:0]          r_rd_row;

  logic                      w_accept;
  logic [ROW_W-1:0]          w_row;
  logic [ROW_SLOTS-1:0]      w_row_cen;
  logic [CUT_ADDR_WIDTH-1:0] w_cut_a;
  logic                      w_cut_wen;
  logic [DATA_WIDTH-1:0]     w_cut_d;
  logic [NB_BE-1:0]          w_cut_ben;
  logic [31:0]               w_cut_q [ROW_SLOTS][NB_CUTS];
  logic [DATA_WIDTH-1:0]     w_rdata;

  if (NB_ROWS > 1) begin : g_row_sel
    assign w_row = i_a[ADDR_WIDTH-1:CUT_ADDR_WIDTH];
  end else begin : g_row_one
    assign w_row = '0;
  end

  // r_init_done doubles as the "ready to grant" flag so GNT stays low in reset.
  assign o_gnt       = i_req & r_init_done;
  assign w_accept    = i_req & o_gnt;
  assign o_init_done = r_init_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= INIT_ZERO ? ST_INIT : ST_READY;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  // Next state plus cut control: zero-fill sweep in INIT, decoded access in READY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_init_cnt;
    w_cut_a     = i_a[CUT_ADDR_WIDTH-1:0];
    w_cut_wen   = i_wen;
    w_cut_d     = i_d;
    w_cut_ben   = ~i_be;
    w_row_cen   = '1;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_init_cnt + CUT_ADDR_WIDTH'(1);
        if (r_init_cnt == CNT_LAST) w_state_nxt = ST_READY;
        w_cut_a   = r_init_cnt;
        w_cut_wen = 1'b0;
        w_cut_d   = '0;
        w_cut_ben = '0;
        w_row_cen = '0;
      end
      default: begin
        if (w_accept) w_row_cen[w_row] = 1'b0;
      end
    endcase
  end

  for (genvar r = 0; r < ROW_SLOTS; r++) begin : g_row
    for (genvar k = 0; k < NB_CUTS; k++) begin : g_cut
      if (r < NB_ROWS) begin : g_mem
        generic_memory #(.ADDR_WIDTH(CUT_ADDR_WIDTH)) u_cut (
          .i_clk   (i_clk),
          .i_initn (1'b1),
          .i_cen   (w_row_cen[r]),
          .i_wen   (w_cut_wen),
          .i_a     (w_cut_a),
          .i_d     (w_cut_d[32*k +: 32]),
          .i_ben   (w_cut_ben[4*k +: 4]),
          .o_q     (w_cut_q[r][k])
        );
      end else begin : g_tie
        assign w_cut_q[r][k] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_vld <= 1'b0;
      r_rd_row <= '0;
    end else begin
      r_rd_vld <= w_accept & i_wen;
      if (w_accept) r_rd_row <= w_row;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < int'(NB_CUTS); k++) begin
      w_rdata[32*k +: 32] = w_cut_q[r_rd_row][k];
    end
  end

  if (OUT_REG) begin : g_oreg
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_vld2 <= 1'b0;
        r_q    <= '0;
      end else begin
        r_vld2 <= r_rd_vld;
        if (r_rd_vld) r_q <= w_rdata;
      end
    end
    assign o_rvalid = r_vld2;
    assign o_q      = r_q;
  end else begin : g_noreg
    assign o_rvalid = r_rd_vld;
    assign o_q      = w_rdata;
  end

endmodule

// File: tb/tb_l2_banked_sram.sv
// Bench for l2_banked_sram: OUT_REG=0 and OUT_REG=1 instances share stimulus and a
// byte-level memory model; an INIT_ZERO=0 instance covers the no-fill start-up.

module tb_l2_banked_sram;

  localparam int unsigned DW  = 64;
  localparam int unsigned CAW = 4;
  localparam int unsigned AW  = CAW + 1;
  localparam int unsigned NBE = DW / 8;
  localparam int unsigned NW  = 1 << AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic           wen;
  logic [AW-1:0]  a;
  logic [DW-1:0]  d;
  logic [NBE-1:0] be;

  logic           gnt0, gnt1, gnt2;
  logic [DW-1:0]  q0, q1, q2;
  logic           rv0, rv1, rv2;
  logic           done0, done1, done2;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [NW];
  logic          p1_vld, p2_vld;
  logic [DW-1:0] p1_dat, p2_dat, exp_q1;

  always #5 clk = ~clk;

  l2_banked_sram #(.DATA_WIDTH(DW), .CUT_ADDR_WIDTH(CAW), .NB_ROWS(2),
                   .OUT_REG(1'b0), .INIT_ZERO(1'b1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt0), .i_wen(wen), .i_a(a),
    .i_d(d), .i_be(be), .o_q(q0), .o_rvalid(rv0), .o_init_done(done0));

  l2_banked_sram #(.DATA_WIDTH(DW), .CUT_ADDR_WIDTH(CAW), .NB_ROWS(2),
                   .OUT_REG(1'b1), .INIT_ZERO(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt1), .i_wen(wen), .i_a(a),
    .i_d(d), .i_be(be), .o_q(q1), .o_rvalid(rv1), .o_init_done(done1));

  l2_banked_sram #(.DATA_WIDTH(DW), .CUT_ADDR_WIDTH(CAW), .NB_ROWS(2),
                   .OUT_REG(1'b0), .INIT_ZERO(1'b0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt2), .i_wen(wen), .i_a(a),
    .i_d(d), .i_be(be), .o_q(q2), .o_rvalid(rv2), .o_init_done(done2));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NW); i++) mem[i] = '0;
    p1_vld = 1'b0; p2_vld = 1'b0;
    p1_dat = '0;   p2_dat = '0;
    exp_q1 = '0;
  endtask

  // Full reset then walk through the 16-cycle zero-fill with REQ held high.
  task automatic full_reset();
    rst = 1'b1; req = 1'b1; wen = 1'b1; a = '0; d = '0; be = '0;
    @(negedge clk);
    chk("rst_gnt0", 64'(gnt0), 64'(0));
    chk("rst_rv0", 64'(rv0), 64'(0));
    chk("rst_rv1", 64'(rv1), 64'(0));
    chk("rst_q1", q1, 64'(0));
    chk("rst_done0", 64'(done0), 64'(0));
    chk("rst_done2", 64'(done2), 64'(0));
    rst = 1'b0;
    #1;
    for (int i = 0; i < (1 << CAW); i++) begin
      chk("init_gnt0", 64'(gnt0), 64'(0));
      chk("init_gnt1", 64'(gnt1), 64'(0));
      chk("init_done0", 64'(done0), 64'(0));
      chk("init_rv0", 64'(rv0), 64'(0));
      chk("init_rv1", 64'(rv1), 64'(0));
      if (i == 1) chk("nofill_done2", 64'(done2), 64'(1));
      @(negedge clk);
    end
    chk("ready_done0", 64'(done0), 64'(1));
    chk("ready_done1", 64'(done1), 64'(1));
    chk("ready_gnt0", 64'(gnt0), 64'(1));
    req = 1'b0;
    clear_model();
  endtask

  // One cycle at a negedge: check outputs against the model, drive, advance the model.
  task automatic step(input logic s_req, input logic s_wen, input logic [AW-1:0] s_a,
                      input logic [DW-1:0] s_d, input logic [NBE-1:0] s_be);
    chk("rvalid0", 64'(rv0), 64'(p1_vld));
    if (p1_vld) chk("q0", q0, p1_dat);
    if (p2_vld) exp_q1 = p2_dat;
    chk("rvalid1", 64'(rv1), 64'(p2_vld));
    chk("q1", q1, exp_q1);
    req = s_req; wen = s_wen; a = s_a; d = s_d; be = s_be;
    #1;
    chk("gnt0", 64'(gnt0), 64'(s_req));
    p2_vld = p1_vld; p2_dat = p1_dat;
    p1_vld = s_req & s_wen;
    if (s_req && s_wen) p1_dat = mem[s_a];
    if (s_req && !s_wen) begin
      for (int b = 0; b < int'(NBE); b++)
        if (s_be[b]) mem[s_a][8*b +: 8] = s_d[8*b +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wen = 1'b1; a = '0; d = '0; be = '0;
    clear_model();
    @(negedge clk);
    full_reset();

    // Fresh memory reads back zero
    step(1'b1, 1'b1, 5'h00, '0, '0);
    step(1'b1, 1'b1, 5'h1F, '0, '0);
    step(1'b1, 1'b1, 5'h10, '0, '0);
    idle();

    // Full write then immediate read of the same word
    step(1'b1, 1'b0, 5'h05, 64'h1122334455667788, 8'hFF);
    step(1'b1, 1'b1, 5'h05, '0, '0);
    chk("raw_q0", q0, 64'h1122334455667788);
    idle();
    chk("raw_q1", q1, 64'h1122334455667788);

    // Partial byte-enable overwrite
    step(1'b1, 1'b0, 5'h05, {DW{1'b1}}, 8'h0F);
    step(1'b1, 1'b1, 5'h05, '0, '0);
    chk("be_q0", q0, 64'h11223344FFFFFFFF);
    idle();

    // Same cut address in both rows, back-to-back reads
    step(1'b1, 1'b0, 5'h03, {8{8'hAA}}, 8'hFF);
    step(1'b1, 1'b0, 5'h13, {8{8'hBB}}, 8'hFF);
    step(1'b1, 1'b1, 5'h03, '0, '0);
    chk("row0_q0", q0, {8{8'hAA}});
    step(1'b1, 1'b1, 5'h13, '0, '0);
    chk("row1_q0", q0, {8{8'hBB}});
    chk("row0_q1", q1, {8{8'hAA}});
    idle();
    chk("row1_q1", q1, {8{8'hBB}});
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom),
           {$urandom, $urandom}, NBE'($urandom));
    end
    idle();
    idle();

    // Reset in the middle of zero-fill: fill must restart from address 0
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_init_done0", 64'(done0), 64'(0));
    full_reset();
    step(1'b1, 1'b1, 5'h05, '0, '0);
    idle();
    idle();

    // Reset with a read in flight: the response is dropped
    step(1'b1, 1'b0, 5'h09, 64'hDEADBEEFCAFEF00D, 8'hFF);
    req = 1'b1; wen = 1'b1; a = 5'h09;
    @(negedge clk);
    full_reset();
    chk("drop_rv0", 64'(rv0), 64'(0));
    chk("drop_rv1", 64'(rv1), 64'(0));
    step(1'b1, 1'b1, 5'h09, '0, '0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
